mse_accumulator: RTL and testbench

- Error-metric stage directly downstream of the approximate-adder FIR filter.
- Each valid cycle it takes the approximate FIR output and the exact-FIR golden output for the same input sample.
- After a warm-up discard, it accumulates the squared error over N_SAMPLES samples and reports the mean squared error and the peak squared error.
- It is the on-chip MSE measurement used to rank approximate adder variants.

---
 rtl/mse_accumulator.sv | 164 ++++++++++++++++
 tb/tb_mse_accumulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mse_accumulator.sv
// Squared-error accumulator behind the approximate FIR.
// Reports mean and peak squared error over N_SAMPLES samples after a warm-up discard.
module mse_accumulator #(
  parameter int N_SAMPLES = 256,
  parameter int LOG2_N    = 8,
  parameter int WARMUP    = 9,
  parameter int ACCW      = 48
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [15:0]       y_approx,
  input  logic [15:0]       y_exact,
  output logic              busy,
  output logic              done,
  output logic [31:0]       mse,
  output logic [31:0]       max_sq_err,
  output logic [LOG2_N:0]   sample_cnt
);

  localparam int WCW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARM,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [WCW-1:0]    warm_cnt_q, warm_cnt_d;
  logic [LOG2_N:0]   sample_cnt_q, sample_cnt_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic [16:0]       diff_q, diff_d;
  logic [31:0]       sq_q, sq_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [31:0]       max_q, max_d;
  logic [31:0]       mse_q, mse_d;
  logic [31:0]       max_sq_q, max_sq_d;
  logic              done_q, done_d;

  logic              accept;
  logic [16:0]       mag;
  logic [ACCW:0]     acc_sum;

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    sample_cnt_d = sample_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    acc_d        = acc_q;
    max_d        = max_q;
    mse_d        = mse_q;
    max_sq_d     = max_sq_q;
    done_d       = 1'b0;
    accept       = (state_q == S_RUN) && in_valid;

    // 17-bit difference of sign-extended operands cannot wrap
    diff_d  = {y_approx[15], y_approx} - {y_exact[15], y_exact};
    mag     = diff_q[16] ? (~diff_q + 17'd1) : diff_q;
    sq_d    = {16'd0, mag[15:0]} * {16'd0, mag[15:0]};
    acc_sum = {1'b0, acc_q} + {{(ACCW - 31){1'b0}}, sq_q};

    if (v2_q) begin
      acc_d = acc_sum[ACCW] ? '1 : acc_sum[ACCW-1:0];
      if (sq_q > max_q) max_d = sq_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d        = '0;
          max_d        = '0;
          sample_cnt_d = '0;
          warm_cnt_d   = '0;
          state_d      = (WARMUP > 0) ? S_WARM : S_RUN;
        end
      end
      S_WARM: begin
        if (in_valid) begin
          warm_cnt_d = warm_cnt_q + 1'b1;
          if (warm_cnt_q == WCW'(WARMUP - 1)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (sample_cnt_q == (LOG2_N + 1)'(N_SAMPLES - 1)) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == 2'd2) begin
          mse_d    = acc_q[LOG2_N+31:LOG2_N];
          max_sq_d = max_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    v1_d = accept;
    v2_d = v1_q;

    if (abort) begin
      state_d      = S_IDLE;
      v1_d         = 1'b0;
      v2_d         = 1'b0;
      sample_cnt_d = '0;
      drain_cnt_d  = '0;
      mse_d        = mse_q;
      max_sq_d     = max_sq_q;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_IDLE;
      warm_cnt_q   <= '0;
      sample_cnt_q <= '0;
      drain_cnt_q  <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      diff_q       <= '0;
      sq_q         <= '0;
      acc_q        <= '0;
      max_q        <= '0;
      mse_q        <= '0;
      max_sq_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      diff_q       <= diff_d;
      sq_q         <= sq_d;
      acc_q        <= acc_d;
      max_q        <= max_d;
      mse_q        <= mse_d;
      max_sq_q     <= max_sq_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign mse        = mse_q;
  assign max_sq_err = max_sq_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_mse_accumulator.sv
// Directed bench for mse_accumulator: two instances, WARMUP=0 and WARMUP=9,
// both with N_SAMPLES=8.
module tb_mse_accumulator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, start0, start1, abort, in_valid;
  logic [15:0] y_approx, y_exact;
  logic        busy0, done0, busy1, done1;
  logic [31:0] mse0, max0, mse1, max1;
  logic [3:0]  cnt0, cnt1;

  int n_chk  = 0;
  int n_fail = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;

  mse_accumulator #(
    .N_SAMPLES(8), .LOG2_N(3), .WARMUP(0), .ACCW(48)
  ) dut0 (
    .clk(clk), .rstN(rstN), .start(start0), .abort(abort),
    .in_valid(in_valid), .y_approx(y_approx), .y_exact(y_exact),
    .busy(busy0), .done(done0), .mse(mse0), .max_sq_err(max0),
    .sample_cnt(cnt0)
  );

  mse_accumulator #(
    .N_SAMPLES(8), .LOG2_N(3), .WARMUP(9), .ACCW(48)
  ) dut1 (
    .clk(clk), .rstN(rstN), .start(start1), .abort(abort),
    .in_valid(in_valid), .y_approx(y_approx), .y_exact(y_exact),
    .busy(busy1), .done(done1), .mse(mse1), .max_sq_err(max1),
    .sample_cnt(cnt1)
  );

  always @(posedge clk) begin
    if (done0) done0_cnt++;
    if (done1) done1_cnt++;
  end

  typedef struct {
    logic [15:0] ya [8];
    logic [15:0] ye [8];
    logic [31:0] emse;
    logic [31:0] emax;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sample(input logic [15:0] ya, input logic [15:0] ye);
    in_valid = 1'b1;
    y_approx = ya;
    y_exact  = ye;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic run_vec(input int k);
    pulse_start0();
    for (int i = 0; i < 8; i++) sample(vecs[k].ya[i], vecs[k].ye[i]);
    chk($sformatf("v%0d_cnt", k), 64'(cnt0), 64'd8);
    chk($sformatf("v%0d_busy_drain", k), 64'(busy0), 64'd1);
    chk($sformatf("v%0d_done_t0", k), 64'(done0), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done_t1", k), 64'(done0), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done_t2", k), 64'(done0), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done_t3", k), 64'(done0), 64'd1);
    chk($sformatf("v%0d_busy_fall", k), 64'(busy0), 64'd0);
    chk($sformatf("v%0d_mse", k), 64'(mse0), 64'(vecs[k].emse));
    chk($sformatf("v%0d_max", k), 64'(max0), 64'(vecs[k].emax));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", k), 64'(done0), 64'd0);
    chk($sformatf("v%0d_cnt_hold", k), 64'(cnt0), 64'd8);
  endtask

  initial begin
    int errs [8];
    int dc;
    errs = '{1, -2, 3, -4, 0, 0, 0, 0};

    for (int i = 0; i < 8; i++) begin
      vecs[0].ya[i] = 16'd1234;
      vecs[0].ye[i] = 16'd1234;
      vecs[1].ye[i] = 16'(-500 + 37 * i);
      vecs[1].ya[i] = 16'(-500 + 37 * i + 4);
      vecs[2].ye[i] = 16'(300 - 11 * i);
      vecs[2].ya[i] = 16'(300 - 11 * i + errs[i]);
      vecs[3].ya[i] = 16'h7FFF;
      vecs[3].ye[i] = 16'h8000;
    end
    vecs[0].emse = 32'd0;          vecs[0].emax = 32'd0;
    vecs[1].emse = 32'd16;         vecs[1].emax = 32'd16;
    vecs[2].emse = 32'd3;          vecs[2].emax = 32'd16;
    vecs[3].emse = 32'd4294836225; vecs[3].emax = 32'd4294836225;

    rstN = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    in_valid = 1'b0; y_approx = '0; y_exact = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_mse", 64'(mse0), 64'd0);
    chk("rst_max", 64'(max0), 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    rstN = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) run_vec(k);

    // Warm-up discard with random in_valid gaps
    dc = done1_cnt;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sample(16'd200, 16'd100);
    end
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sample(16'hFFCE, 16'hFFCE);
    end
    chk("warm_cnt", 64'(cnt1), 64'd8);
    repeat (6) @(negedge clk);
    chk("warm_done_once", 64'(done1_cnt - dc), 64'd1);
    chk("warm_mse", 64'(mse1), 64'd0);
    chk("warm_max", 64'(max1), 64'd0);
    chk("warm_busy", 64'(busy1), 64'd0);

    // Prior result mse=16, then abort mid-run
    run_vec(1);
    pulse_start0();
    for (int i = 0; i < 3; i++) sample(16'd200, 16'd100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_cnt", 64'(cnt0), 64'd0);
    dc = done0_cnt;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 64'(done0_cnt - dc), 64'd0);
    chk("abort_mse_kept", 64'(mse0), 64'd16);
    chk("abort_max_kept", 64'(max0), 64'd16);

    // start while busy must not restart the run
    pulse_start0();
    for (int i = 0; i < 3; i++) sample(16'd12, 16'd10);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_start_cnt", 64'(cnt0), 64'd3);
    chk("busy_start_busy", 64'(busy0), 64'd1);
    for (int i = 0; i < 5; i++) sample(16'd12, 16'd10);
    repeat (3) @(negedge clk);
    chk("busy_start_done", 64'(done0), 64'd1);
    chk("busy_start_mse", 64'(mse0), 64'd4);
    chk("busy_start_max", 64'(max0), 64'd4);
    @(negedge clk);

    // start coincident with abort: stay idle
    start0 = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort  = 1'b0;
    chk("start_abort_busy", 64'(busy0), 64'd0);

    // Reset mid-run clears outputs immediately
    pulse_start0();
    for (int i = 0; i < 3; i++) sample(16'd12, 16'd10);
    rstN = 1'b0;
    #1;
    chk("rstmid_busy", 64'(busy0), 64'd0);
    chk("rstmid_mse", 64'(mse0), 64'd0);
    chk("rstmid_max", 64'(max0), 64'd0);
    chk("rstmid_cnt", 64'(cnt0), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
